// File: rtl/rs232_cap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rs232_cap_pkg
//  Description : Shared types, defaults and helpers for the RS-232 line-event
//                recorder. Defines the 32-bit record layout
//                {lines[7:0], ts[23:0]}, the line bit indices, the big-endian
//                byte offsets within a record, and a saturating counter helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package rs232_cap_pkg;

  // Record geometry and default block parameters
  localparam int REC_W        = 32;
  localparam int TS_FIELD_W   = 24;
  localparam int DEF_LINES    = 8;
  localparam int DEF_TS_WIDTH = 24;
  localparam int DEF_DEPTH    = 128;

  // Monitored line bit positions inside the lines byte
  localparam int LINE_TXD = 7;
  localparam int LINE_RTS = 6;
  localparam int LINE_DTR = 5;
  localparam int LINE_RXD = 4;
  localparam int LINE_CTS = 3;
  localparam int LINE_DSR = 2;
  localparam int LINE_CD  = 1;
  localparam int LINE_RI  = 0;

  // Byte offsets within one record as seen by the packer (big-endian)
  localparam logic [1:0] BYTE_LINES  = 2'd0;
  localparam logic [1:0] BYTE_TS_HI  = 2'd1;
  localparam logic [1:0] BYTE_TS_MID = 2'd2;
  localparam logic [1:0] BYTE_TS_LO  = 2'd3;

  typedef struct packed {
    logic [7:0]            lines;
    logic [TS_FIELD_W-1:0] ts;
  } rec_t;

  // Select one byte of a record in packer byte order
  function automatic logic [7:0] rec_byte(input rec_t rec, input logic [1:0] sel);
    logic [7:0] b;
    b = 8'h00;
    case (sel)
      BYTE_LINES:  b = rec.lines;
      BYTE_TS_HI:  b = rec.ts[23:16];
      BYTE_TS_MID: b = rec.ts[15:8];
      BYTE_TS_LO:  b = rec.ts[7:0];
      default:     b = 8'h00;
    endcase
    return b;
  endfunction

  // 16-bit increment that sticks at all-ones
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rs232_cap_ram.sv
`default_nettype none
// ============================================================================
//  Module      : rs232_cap_ram
//  Description : Simple dual-port record RAM, WORDS x DW. One synchronous
//                write port and one registered read port, both on clk.
//                The array has no reset; contents are only meaningful where
//                the controller has written them.
//  Ports       : clk      - clock
//                i_we     - write enable
//                i_waddr  - write word address
//                i_wdata  - write data
//                i_raddr  - read word address (registered internally)
//                o_rdata  - read data, one cycle after i_raddr
//  Revision    : 1.0 - initial release
// ============================================================================
module rs232_cap_ram #(
  parameter int WORDS = 256,
  parameter int DW    = 32,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [WORDS];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/rs232_event_capture.sv
`default_nettype none
// ============================================================================
//  Module      : rs232_event_capture
//  Description : Timestamped RS-232 line-event recorder. Synchronises the
//                monitored lines, emits one {lines, timestamp} record per
//                cycle in which any line changed, and stores records into the
//                fill half of a ping-pong RAM. A swap pulse freezes the fill
//                half for the USB packer, which reads it bytewise.
//  Ports       : clk           - system clock
//                reset         - synchronous active-high reset
//                line_in       - raw asynchronous line levels
//                swap          - one-cycle pulse: freeze fill half, flip halves
//                rd_addr       - byte address into the frozen half
//                rd_data       - byte at rd_addr, two cycles later
//                rd_count      - records valid in the frozen half
//                rd_overflow   - frozen half dropped at least one event
//                rd_drop_count - events dropped into the frozen half (sat.)
//                fill_count    - records currently in the fill half
//  Revision    : 1.0 - initial release
// ============================================================================
module rs232_event_capture
  import rs232_cap_pkg::*;
#(
  parameter int LINES    = DEF_LINES,
  parameter int TS_WIDTH = DEF_TS_WIDTH,
  parameter int DEPTH    = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [LINES-1:0]         line_in,
  input  logic                     swap,
  input  logic [$clog2(DEPTH)+1:0] rd_addr,
  output logic [7:0]               rd_data,
  output logic [$clog2(DEPTH):0]   rd_count,
  output logic                     rd_overflow,
  output logic [15:0]              rd_drop_count,
  output logic [$clog2(DEPTH):0]   fill_count
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW:0]         C_DEPTH  = (AW+1)'(DEPTH);
  localparam logic [TS_WIDTH-1:0] C_TS_ONE = TS_WIDTH'(1);

  // Synchroniser and change detector; idle RS-232 lines are marked high
  logic [LINES-1:0]    r_s1;
  logic [LINES-1:0]    r_s2;
  logic [LINES-1:0]    r_prev;
  logic [TS_WIDTH-1:0] r_ts_cnt;

  // Fill-side control
  logic                r_fill_sel;
  logic [AW:0]         r_wr_ptr;
  logic                r_fill_ovf;
  logic [15:0]         r_fill_drop;

  // Frozen-side status
  logic [AW:0]         r_rd_count;
  logic                r_rd_overflow;
  logic [15:0]         r_rd_drop_count;

  // Read pipeline
  logic [1:0]          r_rd_sel;
  logic                r_rd_oor;
  logic [7:0]          r_rd_data;

  logic                w_evt;
  logic                w_full;
  logic                w_we;
  logic                w_drop;
  rec_t                w_rec;
  logic [REC_W-1:0]    w_ram_rdata;
  rec_t                w_rd_rec;
  logic                w_oor;

  assign w_evt  = (r_s2 != r_prev);
  assign w_full = (r_wr_ptr == C_DEPTH);
  assign w_we   = w_evt & ~w_full;
  assign w_drop = w_evt & w_full;

  // Narrower timestamp counters are zero-extended into the 24-bit field
  assign w_rec.lines = r_s2;
  assign w_rec.ts    = TS_FIELD_W'(r_ts_cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1            <= '1;
      r_s2            <= '1;
      r_prev          <= '1;
      r_ts_cnt        <= '0;
      r_fill_sel      <= 1'b0;
      r_wr_ptr        <= '0;
      r_fill_ovf      <= 1'b0;
      r_fill_drop     <= 16'h0000;
      r_rd_count      <= '0;
      r_rd_overflow   <= 1'b0;
      r_rd_drop_count <= 16'h0000;
    end else begin
      r_s1     <= line_in;
      r_s2     <= r_s1;
      r_prev   <= r_s2;
      r_ts_cnt <= r_ts_cnt + C_TS_ONE;

      if (swap) begin
        // An event coinciding with swap still belongs to the half being
        // frozen: it is written there (see RAM write address) and counted
        // here, or counted as a drop if that half was already full.
        r_fill_sel      <= ~r_fill_sel;
        r_rd_count      <= r_wr_ptr + {{AW{1'b0}}, w_we};
        r_rd_overflow   <= r_fill_ovf | w_drop;
        r_rd_drop_count <= w_drop ? sat_inc16(r_fill_drop) : r_fill_drop;
        r_wr_ptr        <= '0;
        r_fill_ovf      <= 1'b0;
        r_fill_drop     <= 16'h0000;
      end else begin
        if (w_we) begin
          r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, 1'b1};
        end
        if (w_drop) begin
          r_fill_ovf  <= 1'b1;
          r_fill_drop <= sat_inc16(r_fill_drop);
        end
      end
    end
  end

  // Byte address beyond the last valid record reads as zero; comparing the
  // word index against rd_count is the same as rd_addr >= 4*rd_count.
  assign w_oor = ({1'b0, rd_addr[AW+1:2]} >= r_rd_count);

  rs232_cap_ram #(
    .WORDS (2*DEPTH),
    .DW    (REC_W),
    .AW    (AW+1)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr ({r_fill_sel, r_wr_ptr[AW-1:0]}),
    .i_wdata (w_rec),
    .i_raddr ({~r_fill_sel, rd_addr[AW+1:2]}),
    .o_rdata (w_ram_rdata)
  );

  assign w_rd_rec = w_ram_rdata;

  // Stage 1 (RAM read register + these) / stage 2 (byte mux into rd_data)
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_sel  <= 2'b00;
      r_rd_oor  <= 1'b1;
      r_rd_data <= 8'h00;
    end else begin
      r_rd_sel  <= rd_addr[1:0];
      r_rd_oor  <= w_oor;
      r_rd_data <= r_rd_oor ? 8'h00 : rec_byte(w_rd_rec, r_rd_sel);
    end
  end

  assign rd_data       = r_rd_data;
  assign rd_count      = r_rd_count;
  assign rd_overflow   = r_rd_overflow;
  assign rd_drop_count = r_rd_drop_count;
  assign fill_count    = r_wr_ptr;

endmodule
`default_nettype wire

// File: tb/tb_rs232_event_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs232_event_capture
//  Description : Directed self-checking bench for rs232_event_capture. A
//                second instance with an 8-bit timestamp exercises the
//                counter wrap in a short run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rs232_event_capture;

  logic       clk     = 1'b0;
  logic       reset   = 1'b1;
  logic [7:0] line_in = 8'hFF;
  logic       swap    = 1'b0;
  logic [8:0] rd_addr = 9'd0;

  logic [7:0]  rd_data,       rd_data_s;
  logic [7:0]  rd_count,      rd_count_s;
  logic        rd_overflow,   rd_overflow_s;
  logic [15:0] rd_drop_count, rd_drop_count_s;
  logic [7:0]  fill_count,    fill_count_s;

  int n_checks = 0;
  int n_errors = 0;
  int tb_ts    = 0;   // cycles since reset release == DUT timestamp

  always #5 clk = ~clk;

  rs232_event_capture #(
    .LINES    (8),
    .TS_WIDTH (24),
    .DEPTH    (128)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .line_in       (line_in),
    .swap          (swap),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .rd_count      (rd_count),
    .rd_overflow   (rd_overflow),
    .rd_drop_count (rd_drop_count),
    .fill_count    (fill_count)
  );

  rs232_event_capture #(
    .LINES    (8),
    .TS_WIDTH (8),
    .DEPTH    (128)
  ) dut_s (
    .clk           (clk),
    .reset         (reset),
    .line_in       (line_in),
    .swap          (swap),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data_s),
    .rd_count      (rd_count_s),
    .rd_overflow   (rd_overflow_s),
    .rd_drop_count (rd_drop_count_s),
    .fill_count    (fill_count_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tb_ts++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    tb_ts = 0;
  endtask

  task automatic pulse_swap();
    swap = 1'b1;
    step(1);
    swap = 1'b0;
  endtask

  task automatic read_byte(input int addr, output logic [7:0] b, output logic [7:0] b_s);
    rd_addr = 9'(addr);
    step(2);
    b   = rd_data;
    b_s = rd_data_s;
  endtask

  task automatic read_rec(input int idx, output logic [31:0] w, output logic [31:0] w_s);
    logic [7:0] b, bs;
    w = 32'h0; w_s = 32'h0;
    for (int k = 0; k < 4; k++) begin
      read_byte(idx*4 + k, b, bs);
      w   = {w[23:0], b};
      w_s = {w_s[23:0], bs};
    end
  endtask

  initial begin
    logic [7:0]  b, bs;
    logic [31:0] w, ws, w1, ws1;
    int t0, te, te2;

    // ---- Idle lines produce no records --------------------------------
    step(3);
    check("reset_fill_count", fill_count, 8'd0);
    check("reset_rd_data", rd_data, 8'h00);
    reset = 1'b0;
    tb_ts = 0;
    step(1000);
    check("idle_fill_count", fill_count, 8'd0);
    pulse_swap();
    check("idle_rd_count", rd_count, 8'd0);
    check("idle_rd_overflow", rd_overflow, 1'b0);
    read_byte(0, b, bs);
    check("idle_rd_data", b, 8'h00);

    // ---- Single event at ts=10 ----------------------------------------
    line_in = 8'hFF;
    do_reset();
    step(10);
    line_in = 8'hEF;
    step(3);
    check("single_fill_count", fill_count, 8'd1);
    pulse_swap();
    check("single_rd_count", rd_count, 8'd1);
    read_byte(0, b, bs); check("single_b0", b, 8'hEF);
    read_byte(1, b, bs); check("single_b1", b, 8'h00);
    read_byte(2, b, bs); check("single_b2", b, 8'h00);
    read_byte(3, b, bs); check("single_b3", b, 8'h0C);
    read_byte(4, b, bs); check("single_past_end", b, 8'h00);

    // ---- Overflow: 140 toggles into 128 slots -------------------------
    t0 = 0;
    for (int i = 0; i < 140; i++) begin
      if (i == 0) t0 = tb_ts;
      line_in = line_in ^ 8'h01;
      step(4);
    end
    step(4);
    check("ovf_fill_count", fill_count, 8'd128);
    pulse_swap();
    check("ovf_rd_count", rd_count, 8'd128);
    check("ovf_rd_overflow", rd_overflow, 1'b1);
    check("ovf_drop_count", rd_drop_count, 16'd12);
    check("ovf_fill_cleared", fill_count, 8'd0);
    read_rec(0, w, ws);
    check("ovf_rec0", w, {8'hEE, 24'(t0 + 2)});
    read_rec(1, w1, ws1);
    check("ovf_ts_delta", w1[23:0] - w[23:0], 32'd4);
    read_rec(127, w, ws);
    check("ovf_rec127", w, {8'hEF, 24'(t0 + 2 + 127*4)});

    // ---- Event coinciding with swap -----------------------------------
    line_in = 8'hEB; step(3);
    line_in = 8'hAB; step(3);
    line_in = 8'h2B;
    te = tb_ts;
    step(2);
    pulse_swap();
    check("coinc_rd_count", rd_count, 8'd3);
    check("coinc_rd_overflow", rd_overflow, 1'b0);
    check("coinc_drop_count", rd_drop_count, 16'd0);
    check("coinc_fill_count", fill_count, 8'd0);
    read_rec(2, w, ws);
    check("coinc_rec2", w, {8'h2B, 24'(te + 2)});
    line_in = 8'h3B;
    te2 = tb_ts;
    step(4);
    check("coinc_next_fill", fill_count, 8'd1);
    pulse_swap();
    check("coinc_next_rd_count", rd_count, 8'd1);
    read_rec(0, w, ws);
    check("coinc_next_rec0", w, {8'h3B, 24'(te2 + 2)});

    // ---- Reset mid-fill discards both halves --------------------------
    line_in = 8'hFF;
    step(4);
    pulse_swap();
    check("rst_pre_rd_count", rd_count, 8'd1);
    for (int i = 0; i < 50; i++) begin
      line_in = line_in ^ 8'h01;
      step(2);
    end
    step(4);
    check("rst_pre_fill_count", fill_count, 8'd50);
    reset = 1'b1;
    step(1);
    check("rst_fill_count", fill_count, 8'd0);
    check("rst_rd_count", rd_count, 8'd0);
    check("rst_rd_overflow", rd_overflow, 1'b0);
    reset = 1'b0;
    tb_ts = 0;
    line_in = 8'h7F;
    te = tb_ts;
    step(4);
    check("rst_next_fill", fill_count, 8'd1);
    pulse_swap();
    check("rst_next_rd_count", rd_count, 8'd1);
    read_rec(0, w, ws);
    check("rst_next_rec0", w, {8'h7F, 24'(te + 2)});

    // ---- Timestamp wrap (8-bit instance) ------------------------------
    line_in = 8'hFF;
    do_reset();
    step(252);
    line_in = 8'hFE;
    step(3);
    line_in = 8'hFF;
    step(4);
    pulse_swap();
    check("wrap_rd_count_s", rd_count_s, 8'd2);
    check("wrap_rd_count", rd_count, 8'd2);
    read_rec(0, w, ws);
    check("wrap_rec0_s", ws, 32'hFE0000FE);
    check("wrap_rec0", w, 32'hFE0000FE);
    read_rec(1, w, ws);
    check("wrap_rec1_s", ws, 32'hFF000001);
    check("wrap_rec1", w, 32'hFF000101);
    read_byte(8, b, bs);
    check("wrap_past_end_s", bs, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
